// File: rtl/timer_scheduler.sv
// Arbitrates NUM_REQ one-shot delay requests onto one shared Timer instance.
// Define TMR_SCHED_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module timer_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BITS    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BITS-1:0]   delay,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      tmr_enable,
  output logic [BITS-1:0]           tmr_final_value,
  input  logic                      tmr_tick
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [BITS-1:0]     r_final;
  logic                w_found;
  logic [PW-1:0]       w_win_idx;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [BITS-1:0]     w_win_delay;

`ifdef TMR_SCHED_RR_EN
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_probe;

  // Search starts one past the last winner, wrapping at NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_probe   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_probe = PW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_probe]) begin
        w_found   = 1'b1;
        w_win_idx = w_probe;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= PW'(NUM_REQ - 1);
    else if (r_state == S_IDLE && w_found)
      r_ptr <= w_win_idx;
  end
`else
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k]) begin
        w_found   = 1'b1;
        w_win_idx = PW'(k);
      end
    end
  end
`endif

  always_comb begin
    w_win_oh    = '0;
    w_win_delay = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_found && PW'(k) == w_win_idx) begin
        w_win_oh[k] = 1'b1;
        w_win_delay = delay[k*BITS +: BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    grant           = r_grant;
    done            = '0;
    busy            = (r_state != S_IDLE);
    tmr_enable      = 1'b0;
    tmr_final_value = r_final;
    unique case (r_state)
      S_IDLE: if (w_found) w_next = S_LOAD;
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        tmr_enable = 1'b1;
        if (tmr_tick) w_next = S_DONE;
      end
      S_DONE: begin
        done   = r_grant;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job data is captured only on the IDLE->LOAD edge; later req/delay changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_final <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_grant <= w_win_oh;
      r_final <= w_win_delay;
    end else if (r_state == S_DONE) begin
      r_grant <= '0;
    end
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one `Timer` instance among `NUM_REQ` requesters. Each requester asks for a one-shot delay of `F+1` enabled timer cycles. The block arbitrates between requesters, loads the winner's final value into the timer, and gates the timer enable. It returns a one-cycle `done` pulse when the timer ticks. It sits between the PWM channel logic and the shared timer, and owns the timer's `enable` and `Final_Value` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `BITS`, default 8: timer width; must equal the `Timer` instance's `BITS`.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset. The top level drives the timer's active-low reset with `~reset`.
- `req` input `NUM_REQ`: level request per requester. Held high until that requester's `done`.
- `delay` input `NUM_REQ*BITS`: final value for requester i at `[i*BITS +: BITS]`. Stable while `req[i]` is high.
- `grant` output `NUM_REQ`: one-hot grant, high in LOAD, RUN and DONE.
- `done` output `NUM_REQ`: one-cycle pulse in DONE for the granted requester.
- `busy` output 1: high whenever state ≠ IDLE.
- `tmr_enable` output 1: drives the timer's `enable`; high only in RUN.
- `tmr_final_value` output `BITS`: drives the timer's `Final_Value`; the latched delay of the current job.
- `tmr_tick` input 1: the timer's `tick` output, which is combinational.

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoding is free; all outputs are Moore functions of registered state.
- IDLE:
  - If any `req` bit is high, select the winner.
  - Register one-hot `grant`.
  - Latch the winner's `delay` into `tmr_final_value`.
  - Go to LOAD. Otherwise stay in IDLE.
- LOAD: `tmr_enable`=0 for exactly one cycle, so `Final_Value` settles while the timer counter rests at 0. Go to RUN.
- RUN:
  - `tmr_enable`=1.
  - On the edge where `tmr_tick`=1, go to DONE. The timer clears itself to 0 on that same edge.
  - `tmr_tick` is ignored in every other state.
- DONE:
  - `tmr_enable`=0.
  - `done[winner]`=1 for one cycle.
  - Go to IDLE. `grant` clears on entry to IDLE.
- Invariant: the timer counter is 0 whenever state is IDLE or LOAD. This holds because enable is dropped only after a tick edge, and both blocks reset together.
- Arbitration and the priority pointer are defined under Configuration.
- Changes to `req` or `delay` after the IDLE→LOAD edge are ignored until the next IDLE. Dropping `req[i]` mid-job does not abort the job; `done[i]` still pulses.
- A requester whose `req` is still high in IDLE after its `done` is re-arbitrated as a new job.
- `delay`=0 is legal and gives one RUN cycle. `delay`=2^BITS−1 gives 2^BITS RUN cycles; no wrap beyond that.

## Timing
- Reset values: state=IDLE, `grant`=0, `done`=0, `busy`=0, `tmr_enable`=0, `tmr_final_value`=0, RR pointer=`NUM_REQ-1`.
- `req` first sampled high in IDLE at cycle 0:
  - LOAD at cycle 1.
  - RUN at cycles 2 .. F+2.
  - DONE (`done` pulse) at cycle F+3.
  - IDLE at cycle F+4.
- Back-to-back jobs: the next LOAD is at the earliest cycle F+5. Minimum job period is F+4 cycles.
- `busy` rises at cycle 1 and falls at cycle F+4.
- Reset asserted mid-job: all outputs go to reset values immediately and asynchronously. The timer is reset by the same signal. No `done` is produced for the aborted job.

## Configuration
- `TMR_SCHED_RR_EN` defined:
  - Round-robin arbitration. The search starts at index (pointer+1) mod `NUM_REQ`.
  - The pointer updates to the winner index on the IDLE→LOAD edge.
  - After reset, index 0 is searched first.
- `TMR_SCHED_RR_EN` not defined:
  - Fixed priority; the lowest set index wins.
  - No pointer register exists.

## Test plan
- Reset then single request: `req`=4'b0001, delay0=3 → LOAD at cycle 1; `tmr_enable` high for cycles 2–5; `done[0]` pulse at cycle 6; `busy` low at cycle 7.
- Zero delay: delay2=0, `req[2]` only → exactly one RUN cycle; `done[2]` at cycle 3.
- Contention with RR: all four `req` held high, all delays=1 → grant order 0,1,2,3,0 with each `done` 5 cycles apart. Without the macro: grant order 0,0,0…
- Mid-job change: `delay` changed and `req` dropped during RUN → original RUN length kept; `done` still pulses; no new job started.
- Reset mid-RUN: assert `reset` at cycle 3 of a delay=10 job → all outputs 0 immediately; no `done`. A new job after release times correctly from counter 0.
- Max delay, `BITS`=4: delay=15 → 16 RUN cycles; `done` at cycle 18.
